// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default sizing for the register-file write-port arbiter.
// The state encoding is fixed so external checkers can decode the fsm_state port.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_AW        = 5;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 8;
  localparam int ONEHOT_W      = 32;

endpackage

// File: rtl/decoder_5bits.sv
// 5-to-32 enable-gated one-hot decoder for per-register write enables.
module decoder_5bits (
  input  logic [4:0]  sel,
  input  logic        en,
  output logic [31:0] out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port, with bounded locked bursts.
// Grants are combinational; the accepted write is presented to the regfile one cycle later.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      stall,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      ctrl_writeEnable,
  output logic [AW-1:0]             ctrl_writeReg,
  output logic [DW-1:0]             data_writeReg,
  output logic [ONEHOT_W-1:0]       write_onehot,
  output logic                      zero_drop,
  output logic [$clog2(NREQ)-1:0]   owner,
  output state_t                    fsm_state
);

  // Handshake: a beat from requester i transfers in the cycle where
  // req_valid[i] & req_ready[i] are both high; ready may rise without valid.

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [OW:0]   NREQ_W     = (OW+1)'(NREQ);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t          state, state_n;
  logic [OW-1:0]   rr_ptr, rr_ptr_n;
  logic [OW-1:0]   owner_n;
  logic [BW-1:0]   beat_cnt, beat_cnt_n;

  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0]   valid_rot;
  logic              pick_found;
  logic [OW-1:0]     pick_off;
  logic [OW:0]       pick_sum;
  logic [OW-1:0]     pick_idx;
  logic [OW-1:0]     grant_idx;
  logic              accept;
  logic [AW-1:0]     acc_addr;
  logic [DW-1:0]     acc_data;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
    logic [OW:0] n;
    n = {1'b0, i} + (OW+1)'(1);
    if (n >= NREQ_W) n = '0;
    return n[OW-1:0];
  endfunction

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    valid_dbl  = {req_valid, req_valid} >> rr_ptr;
    valid_rot  = valid_dbl[NREQ-1:0];
    pick_found = 1'b0;
    pick_off   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (valid_rot[j]) begin
        pick_found = 1'b1;
        pick_off   = OW'(j);
      end
    end
    pick_sum = {1'b0, pick_off} + {1'b0, rr_ptr};
    if (pick_sum >= NREQ_W) pick_sum = pick_sum - NREQ_W;
    pick_idx = pick_sum[OW-1:0];
  end

  always_comb begin
    grant_idx = (state == LOCKED) ? owner : pick_idx;
    accept    = |(req_valid & req_ready);
    acc_addr  = req_addr[grant_idx*AW +: AW];
    acc_data  = req_data[grant_idx*DW +: DW];
  end

  // State register
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Next-state logic; nothing advances without an accepted beat, which also covers stall.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    if (accept) begin
      owner_n = grant_idx;
      case (state)
        IDLE: begin
          if (req_lock[grant_idx] && (MAX_BURST > 1)) begin
            state_n    = LOCKED;
            beat_cnt_n = BW'(1);
          end else begin
            rr_ptr_n = wrap_inc(grant_idx);
          end
        end
        LOCKED: begin
          if (!req_lock[owner] || (beat_cnt == BURST_LAST)) begin
            state_n    = IDLE;
            rr_ptr_n   = wrap_inc(owner);
            beat_cnt_n = '0;
          end else begin
            beat_cnt_n = beat_cnt + BW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Grant outputs; a locked owner keeps the port even while its valid is low.
  always_comb begin
    req_ready = '0;
    if (!ctrl_reset && !stall) begin
      if (state == LOCKED)  req_ready[owner]    = 1'b1;
      else if (pick_found)  req_ready[pick_idx] = 1'b1;
    end
  end

  // Write stage: a beat to r0 is consumed but never reaches the regfile.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      zero_drop        <= 1'b0;
    end else if (accept) begin
      ctrl_writeEnable <= |acc_addr;
      ctrl_writeReg    <= acc_addr;
      data_writeReg    <= acc_data;
      zero_drop        <= ~|acc_addr;
    end else begin
      ctrl_writeEnable <= 1'b0;
      zero_drop        <= 1'b0;
    end
  end

  assign fsm_state = state;

  decoder_5bits u_decoder (
    .sel (5'(ctrl_writeReg)),
    .en  (ctrl_writeEnable),
    .out (write_onehot)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenario bench for regfile_write_arbiter (NREQ=4, AW=5, DW=32, MAX_BURST=8).
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic              stall;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              ctrl_writeEnable;
  logic [AW-1:0]     ctrl_writeReg;
  logic [DW-1:0]     data_writeReg;
  logic [31:0]       write_onehot;
  logic              zero_drop;
  logic [1:0]        owner;
  state_t            fsm_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .stall(stall),
    .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .write_onehot(write_onehot), .zero_drop(zero_drop),
    .owner(owner), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drivers: requester i writes reg i+1 with data 0x100+i unless overridden.
  task automatic drive_all(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] lock);
    req_valid = valid;
    req_lock  = lock;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = 32'h100 + i;
    end
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    stall      = 1'b0;
    drive_all(4'b1111, 4'b0000);
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000); end
    checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%0d/%h exp=0/0", ctrl_writeReg, data_writeReg); end
    checks++; if (zero_drop !== 1'b0 || owner !== 2'd0 || write_onehot !== 32'd0) begin errors++; $display("FAIL reset_misc got zd=%b own=%0d oh=%h exp 0", zero_drop, owner, write_onehot); end
    ctrl_reset = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    drive_all(4'b1111, 4'b0000);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      checks++; if (req_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rr_grant got=%b exp=%b", req_ready, 4'b0001 << g); end
      tick();
      checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'(g + 1) || data_writeReg !== 32'h100 + 32'(g)) begin
        errors++; $display("FAIL rr_write got we=%b reg=%0d data=%h exp we=1 reg=%0d data=%h", ctrl_writeEnable, ctrl_writeReg, data_writeReg, g + 1, 32'h100 + 32'(g));
      end
      checks++; if (write_onehot !== (32'd1 << (g + 1)) || owner !== g) begin errors++; $display("FAIL rr_onehot got oh=%h own=%0d exp oh=%h own=%0d", write_onehot, owner, 32'd1 << (g + 1), g); end
    end
    drive_all(4'b0000, 4'b0000);
    tick();
    checks++; if (ctrl_writeEnable !== 1'b0 || write_onehot !== 32'd0) begin errors++; $display("FAIL rr_idle_we got we=%b oh=%h exp 0", ctrl_writeEnable, write_onehot); end
  endtask

  task automatic test_r0_write();
    drive_all(4'b0010, 4'b0000);
    req_addr[1*AW +: AW] = 5'd0;
    req_data[1*DW +: DW] = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL r0_grant got=%b exp=0010", req_ready); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b0 || zero_drop !== 1'b1 || write_onehot !== 32'd0) begin
      errors++; $display("FAIL r0_drop got we=%b zd=%b oh=%h exp we=0 zd=1 oh=0", ctrl_writeEnable, zero_drop, write_onehot);
    end
    checks++; if (data_writeReg !== 32'hDEADBEEF || ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL r0_data got reg=%0d data=%h exp reg=0 data=deadbeef", ctrl_writeReg, data_writeReg); end
    drive_all(4'b0000, 4'b0000);
    tick();
    checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL r0_pulse got zd=%b exp=0", zero_drop); end
  endtask

  // rr_ptr is 2 here, so req2 wins first and locks for exactly 8 beats.
  task automatic test_burst();
    drive_all(4'b1111, 4'b0100);
    for (int b = 0; b < 8; b++) begin
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL burst_grant beat=%0d got=%b exp=0100", b, req_ready); end
      tick();
      checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || owner !== 2'd2) begin
        errors++; $display("FAIL burst_write beat=%0d got we=%b reg=%0d own=%0d exp we=1 reg=3 own=2", b, ctrl_writeEnable, ctrl_writeReg, owner);
      end
    end
    checks++; if (req_ready !== 4'b1000 || fsm_state !== IDLE) begin errors++; $display("FAIL burst_release got rdy=%b st=%0d exp rdy=1000 st=0", req_ready, fsm_state); end
    drive_all(4'b1111, 4'b0000);
    tick();
    checks++; if (ctrl_writeReg !== 5'd4 || owner !== 2'd3) begin errors++; $display("FAIL burst_next got reg=%0d own=%0d exp reg=4 own=3", ctrl_writeReg, owner); end
  endtask

  // rr_ptr is 0: req0 locks, idles two cycles while still holding the port, then finishes.
  task automatic test_locked_idle();
    drive_all(4'b1111, 4'b0001);
    for (int b = 0; b < 2; b++) begin
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lidle_grant beat=%0d got=%b exp=0001", b, req_ready); end
      tick();
    end
    checks++; if (fsm_state !== LOCKED) begin errors++; $display("FAIL lidle_state got=%0d exp=1", fsm_state); end
    drive_all(4'b1110, 4'b0001);
    for (int c = 0; c < 2; c++) begin
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lidle_hold cyc=%0d got=%b exp=0001", c, req_ready); end
      tick();
      checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL lidle_we cyc=%0d got=%b exp=0", c, ctrl_writeEnable); end
    end
    drive_all(4'b1111, 4'b0000);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lidle_resume got=%b exp=0001", req_ready); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd1) begin errors++; $display("FAIL lidle_last got we=%b reg=%0d exp we=1 reg=1", ctrl_writeEnable, ctrl_writeReg); end
    checks++; if (req_ready !== 4'b0010 || fsm_state !== IDLE) begin errors++; $display("FAIL lidle_exit got rdy=%b st=%0d exp rdy=0010 st=0", req_ready, fsm_state); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0000", c, req_ready); end
      tick();
      checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL stall_we cyc=%0d got=%b exp=0", c, ctrl_writeEnable); end
    end
    stall = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_resume got=%b exp=0010", req_ready); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd2) begin errors++; $display("FAIL stall_w1 got we=%b reg=%0d exp we=1 reg=2", ctrl_writeEnable, ctrl_writeReg); end
    tick();
    checks++; if (ctrl_writeReg !== 5'd3 || owner !== 2'd2) begin errors++; $display("FAIL stall_w2 got reg=%0d own=%0d exp reg=3 own=2", ctrl_writeReg, owner); end
  endtask

  // rr_ptr is 3: req3 locks, then reset lands mid-burst with a write in flight.
  task automatic test_reset_mid();
    drive_all(4'b1111, 4'b1000);
    tick();
    checks++; if (fsm_state !== LOCKED || req_ready !== 4'b1000) begin errors++; $display("FAIL rmid_lock got st=%0d rdy=%b exp st=1 rdy=1000", fsm_state, req_ready); end
    #2;
    ctrl_reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000 || ctrl_writeEnable !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("FAIL rmid_async got rdy=%b we=%b own=%0d exp 0", req_ready, ctrl_writeEnable, owner);
    end
    checks++; if (ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0 || fsm_state !== IDLE) begin
      errors++; $display("FAIL rmid_clear got reg=%0d data=%h st=%0d exp 0", ctrl_writeReg, data_writeReg, fsm_state);
    end
    tick();
    ctrl_reset = 1'b0;
    drive_all(4'b1111, 4'b0000);
    checks++; if (req_ready !== 4'b0001 || ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL rmid_first got rdy=%b we=%b exp rdy=0001 we=0", req_ready, ctrl_writeEnable); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd1) begin errors++; $display("FAIL rmid_write got we=%b reg=%0d exp we=1 reg=1", ctrl_writeEnable, ctrl_writeReg); end
  endtask

  initial begin
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    test_reset();
    test_round_robin();
    test_r0_write();
    test_burst();
    test_locked_idle();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
